coef_scan_serializer: RTL and testbench
=======================================

Name: coef_scan_serializer

Overview:
- Sits directly downstream of the pre-quantisation stage (quantised 8x8 coefficient blocks), upstream of the entropy coder.
- Captures one full 8x8 block in a single cycle into a ping-pong pair of block buffers.
- Emits the 64 coefficients one per cycle, in ProRes scan order, over a valid/ready stream.
- Carries the block's luma/chroma tag alongside the coefficients.

Parameters:
- DATA_W, 32, coefficient width in and out (signed, passed through unmodified).

Ports:
- CLOCK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- input_valid  in  1  one-cycle pulse; INPUT_DATA holds a complete block
- INPUT_DATA  in  DATA_W x [8][8]  signed quantised block, [row][col]
- is_y  in  1  block tag, sampled with input_valid
- in_ready  out  1  at least one buffer empty
- overflow  out  1  sticky; a block was dropped
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  signed coefficient
- out_index  out  6  scan position 0..63
- out_last  out  1  out_index==63
- out_is_y  out  1  tag of the block being drained

Behaviour:
- Reset (RESET==0 at a posedge):
  - Both buffers EMPTY; write select=0, read select=0.
  - out_valid=0, out_data=0, out_index=0, out_last=0, out_is_y=0, overflow=0; in_ready=1 in the following cycle.
  - Reset mid-drain discards all buffered data.
- Buffer state: each buffer is EMPTY or FULL. in_ready = either buffer EMPTY, decoded from registered state.
- Capture:
  - On input_valid with in_ready=1, the block and is_y are written to the buffer at write select; that buffer becomes FULL and write select toggles.
  - On input_valid with in_ready=0, the block is dropped, overflow is set to 1 (cleared only by reset), and buffer state is unchanged.
  - in_ready is evaluated from state before the edge, so a buffer freed at the same edge does not accept that cycle's block.
- Read FSM states: IDLE and DRAIN.
  - IDLE -> DRAIN when the buffer at read select is FULL. In the next cycle out_valid=1, out_index=0, out_data=buf[scan[0]].
  - Capture at edge t with the reader IDLE: first coefficient visible in cycle t+1 (latency 1).
  - DRAIN: a coefficient is held stable while out_valid=1 and out_ready=0.
  - On a handshake (out_valid & out_ready) with out_index<63, out_index increments.
  - On a handshake with out_index==63: the buffer becomes EMPTY and read select toggles.
    - If the other buffer is FULL, out_index=0 of the next block is presented the next cycle, with no bubble.
    - Otherwise go to IDLE with out_valid=0.
- Scan address: scan[out_index] gives a linear address row*8+col. Progressive table: 0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63.
- out_last = (out_index==63) & out_valid.
- Simultaneous capture into the free buffer and drain of the other is fully supported.
- All outputs are registered; there is no combinational path from out_ready to out_valid.

Optional Feature:
- Macro: COEF_SCAN_INTERLACED_EN.
- Defined:
  - Adds input is_interlaced (1 bit), sampled and stored per buffer with input_valid.
  - Interlaced blocks use the table 0,8,1,9,16,24,17,25,2,10,3,11,18,26,19,27,32,40,33,34,41,48,56,49,42,35,43,50,57,58,51,59,4,12,5,6,13,20,28,21,14,7,15,22,29,36,44,37,30,23,31,38,45,52,60,53,46,39,47,54,61,62,55,63.
- Undefined: the port is absent and only the progressive table exists.

Decomposition:
- Shared package prores_scan_pkg holds:
  - the localparam arrays PROGRESSIVE_SCAN[64] and INTERLACED_SCAN[64] (6-bit entries)
  - the typedef buf_state_t {BUF_EMPTY, BUF_FULL}
  - the typedef rd_state_t {RD_IDLE, RD_DRAIN}
- One sub-module is natural: coef_block_buf, a single 8x8 storage bank with a full-block write port and a 6-bit linear read address. It is instantiated twice.

Test Plan:
- Single block, out_ready=1: INPUT_DATA[r][c]=r*8+c, is_y=1 -> 64 beats in consecutive cycles starting 1 cycle after capture. out_data sequence equals the progressive table (0,1,8,9,2,...). out_last only on beat 64. out_is_y=1.
- Back-to-back: block A (all values +5), then block B (all values -7) 3 cycles later, out_ready=1 -> 64x5 then immediately 64x(-7), no idle cycle between them. in_ready stays 1.
- Backpressure: out_ready toggles 1,0,1,0 -> each coefficient is held while out_ready=0. Total 128 cycles for 64 beats; order is unchanged.
- Overflow: three blocks captured with out_ready=0 -> the third is dropped and overflow=1. After releasing out_ready, exactly 128 beats (blocks 1 and 2) are produced.
- Reset mid-drain: RESET=0 at beat 30 -> next cycle out_valid=0, overflow=0, in_ready=1. A new block then drains from out_index=0.
- With COEF_SCAN_INTERLACED_EN, is_interlaced=1, ramp data -> out_data sequence 0,8,1,9,16,24,...,63.

Source files
------------

// File: rtl/prores_scan_pkg.sv
// ---------------------------------------------------------------------------
// prores_scan_pkg
//
// Shared definitions for the ProRes coefficient scan serializer:
//   PROGRESSIVE_SCAN / INTERLACED_SCAN : scan position -> linear address
//                                        (row*8 + col) of an 8x8 block
//   buf_state_t                        : occupancy of one block buffer
//   rd_state_t                         : read-side FSM states
//   scan_addr()                        : picks the table for a block and
//                                        returns the address at a position
// ---------------------------------------------------------------------------
package prores_scan_pkg;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_t;

    localparam logic [5:0] PROGRESSIVE_SCAN [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11,
        16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14,
        21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42,
        49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [5:0] INTERLACED_SCAN [64] = '{
         0,  8,  1,  9, 16, 24, 17, 25,
         2, 10,  3, 11, 18, 26, 19, 27,
        32, 40, 33, 34, 41, 48, 56, 49,
        42, 35, 43, 50, 57, 58, 51, 59,
         4, 12,  5,  6, 13, 20, 28, 21,
        14,  7, 15, 22, 29, 36, 44, 37,
        30, 23, 31, 38, 45, 52, 60, 53,
        46, 39, 47, 54, 61, 62, 55, 63
    };

    function automatic logic [5:0] scan_addr(input logic interlaced,
                                             input logic [5:0] idx);
        return interlaced ? INTERLACED_SCAN[idx] : PROGRESSIVE_SCAN[idx];
    endfunction

endpackage

// File: rtl/coef_block_buf.sv
// ---------------------------------------------------------------------------
// coef_block_buf
//
// One 8x8 coefficient storage bank. The whole block plus its tags are
// written in a single cycle; coefficients are read asynchronously through
// a 6-bit linear address (row*8 + col).
//
// Ports:
//   CLOCK             clock
//   write_en          capture write_data / tags at the next edge
//   write_data        full block, [row][col]
//   write_is_y        luma/chroma tag stored with the block
//   write_interlaced  scan-type tag stored with the block
//   read_addr         linear coefficient address
//   read_data         coefficient at read_addr
//   stored_is_y       tag of the stored block
//   stored_interlaced scan-type tag of the stored block
//
// Storage is not reset; the owner tracks whether the contents are valid.
// ---------------------------------------------------------------------------
module coef_block_buf
    import prores_scan_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     CLOCK,
    input  logic                     write_en,
    input  logic signed [DATA_W-1:0] write_data [8][8],
    input  logic                     write_is_y,
    input  logic                     write_interlaced,
    input  logic [5:0]               read_addr,
    output logic signed [DATA_W-1:0] read_data,
    output logic                     stored_is_y,
    output logic                     stored_interlaced
);

    logic signed [DATA_W-1:0] mem [8][8];

    always_ff @(posedge CLOCK) begin
        if (write_en) begin
            mem               <= write_data;
            stored_is_y       <= write_is_y;
            stored_interlaced <= write_interlaced;
        end
    end

    assign read_data = mem[read_addr[5:3]][read_addr[2:0]];

endmodule

// File: rtl/coef_scan_serializer.sv
// ---------------------------------------------------------------------------
// coef_scan_serializer
//
// Captures quantised 8x8 blocks into a ping-pong pair of buffers and emits
// the 64 coefficients one per cycle in ProRes scan order over a
// valid/ready stream, tagged with the block's luma/chroma flag.
//
// Ports:
//   CLOCK, RESET   clock; synchronous active-low reset
//   input_valid    one-cycle pulse, INPUT_DATA holds a complete block
//   INPUT_DATA     signed block, [row][col]
//   is_y           block tag, sampled with input_valid
//   is_interlaced  (COEF_SCAN_INTERLACED_EN only) selects interlaced scan
//   in_ready       at least one buffer empty
//   overflow       sticky, a block arrived with no free buffer
//   out_valid/out_ready/out_data/out_index/out_last/out_is_y  output stream
//
// Build option: define COEF_SCAN_INTERLACED_EN to add the is_interlaced
// input and the interlaced scan table. Without it only progressive scan
// exists.
// ---------------------------------------------------------------------------
module coef_scan_serializer
    import prores_scan_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     input_valid,
    input  logic signed [DATA_W-1:0] INPUT_DATA [8][8],
    input  logic                     is_y,
`ifdef COEF_SCAN_INTERLACED_EN
    input  logic                     is_interlaced,
`endif
    output logic                     in_ready,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [5:0]               out_index,
    output logic                     out_last,
    output logic                     out_is_y
);

    logic in_interlaced;

`ifdef COEF_SCAN_INTERLACED_EN
    assign in_interlaced = is_interlaced;
`else
    assign in_interlaced = 1'b0;
`endif

    buf_state_t               buf_state      [2];
    buf_state_t               buf_state_next [2];
    rd_state_t                rd_state, rd_state_next;
    logic                     wr_sel, wr_sel_next;
    logic                     rd_sel, rd_sel_next;
    logic                     overflow_next;
    logic                     out_valid_next;
    logic                     out_last_next;
    logic                     out_is_y_next;
    logic [5:0]               out_index_next;
    logic signed [DATA_W-1:0] out_data_next;

    logic                     capture;
    logic                     handshake;
    logic [1:0]               write_en;
    logic [5:0]               read_addr         [2];
    logic signed [DATA_W-1:0] read_data         [2];
    logic                     stored_is_y       [2];
    logic                     stored_interlaced [2];
    logic [5:0]               bypass_addr;
    logic signed [DATA_W-1:0] bypass_data;

    assign in_ready  = (buf_state[0] == BUF_EMPTY) || (buf_state[1] == BUF_EMPTY);
    assign capture   = input_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign write_en  = {capture && wr_sel, capture && !wr_sel};

    for (genvar i = 0; i < 2; i++) begin : g_bank
        coef_block_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .CLOCK             (CLOCK),
            .write_en          (write_en[i]),
            .write_data        (INPUT_DATA),
            .write_is_y        (is_y),
            .write_interlaced  (in_interlaced),
            .read_addr         (read_addr[i]),
            .read_data         (read_data[i]),
            .stored_is_y       (stored_is_y[i]),
            .stored_interlaced (stored_interlaced[i])
        );
    end

    // The bank being drained is pre-addressed at the coefficient after the
    // one on the output register, so a handshake loads the next value with
    // no extra stage. Any other bank (or the drain bank before it starts)
    // sits at scan position 0, ready to start a block immediately.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            read_addr[i] = scan_addr(stored_interlaced[i], 6'd0);
            if ((rd_sel == 1'(i)) && (rd_state == RD_DRAIN)) begin
                read_addr[i] = scan_addr(stored_interlaced[i], out_index + 6'd1);
            end
        end
    end

    // A block written this cycle is not yet in its bank, so its first
    // coefficient is taken straight from the input to reach the output one
    // cycle after capture.
    assign bypass_addr = scan_addr(in_interlaced, 6'd0);
    assign bypass_data = INPUT_DATA[bypass_addr[5:3]][bypass_addr[2:0]];

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            buf_state[0] <= BUF_EMPTY;
            buf_state[1] <= BUF_EMPTY;
            rd_state     <= RD_IDLE;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
            out_is_y     <= 1'b0;
        end else begin
            buf_state    <= buf_state_next;
            rd_state     <= rd_state_next;
            wr_sel       <= wr_sel_next;
            rd_sel       <= rd_sel_next;
            overflow     <= overflow_next;
            out_valid    <= out_valid_next;
            out_data     <= out_data_next;
            out_index    <= out_index_next;
            out_last     <= out_last_next;
            out_is_y     <= out_is_y_next;
        end
    end

    // Capture side fills the bank at wr_sel; the reader drains the bank at
    // rd_sel. A block that lands in the next bank on the same edge the
    // current block finishes is chained without a bubble, exactly as if it
    // had already been full.
    always_comb begin
        buf_state_next = buf_state;
        rd_state_next  = rd_state;
        wr_sel_next    = wr_sel;
        rd_sel_next    = rd_sel;
        overflow_next  = overflow;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_index_next = out_index;
        out_is_y_next  = out_is_y;

        if (capture) begin
            buf_state_next[wr_sel] = BUF_FULL;
            wr_sel_next            = !wr_sel;
        end
        if (input_valid && !in_ready) begin
            overflow_next = 1'b1;
        end

        case (rd_state)
            RD_IDLE: begin
                if (buf_state[rd_sel] == BUF_FULL) begin
                    rd_state_next  = RD_DRAIN;
                    out_valid_next = 1'b1;
                    out_index_next = 6'd0;
                    out_data_next  = read_data[rd_sel];
                    out_is_y_next  = stored_is_y[rd_sel];
                end else if (capture && (wr_sel == rd_sel)) begin
                    rd_state_next  = RD_DRAIN;
                    out_valid_next = 1'b1;
                    out_index_next = 6'd0;
                    out_data_next  = bypass_data;
                    out_is_y_next  = is_y;
                end
            end
            RD_DRAIN: begin
                if (handshake) begin
                    if (out_index != 6'd63) begin
                        out_index_next = out_index + 6'd1;
                        out_data_next  = read_data[rd_sel];
                    end else begin
                        buf_state_next[rd_sel] = BUF_EMPTY;
                        rd_sel_next            = !rd_sel;
                        out_index_next         = 6'd0;
                        if (buf_state[!rd_sel] == BUF_FULL) begin
                            out_data_next = read_data[!rd_sel];
                            out_is_y_next = stored_is_y[!rd_sel];
                        end else if (capture && (wr_sel != rd_sel)) begin
                            out_data_next = bypass_data;
                            out_is_y_next = is_y;
                        end else begin
                            rd_state_next  = RD_IDLE;
                            out_valid_next = 1'b0;
                        end
                    end
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase

        out_last_next = out_valid_next && (out_index_next == 6'd63);
    end

endmodule

// File: tb/tb_coef_scan_serializer.sv
// ---------------------------------------------------------------------------
// tb_coef_scan_serializer
//
// Self-checking bench for coef_scan_serializer. A block-level reference
// model (count of held blocks, queue of expected beats built from the scan
// tables) is compared against the DUT every cycle; a scenario table drives
// the directed cases, followed by reset-mid-drain and randomized traffic.
// Define COEF_SCAN_INTERLACED_EN to also exercise the interlaced scan.
// ---------------------------------------------------------------------------
module tb_coef_scan_serializer;

    localparam int DATA_W = 32;

    localparam int PROG_TBL [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    localparam int INTL_TBL [64] = '{
         0,  8,  1,  9, 16, 24, 17, 25,  2, 10,  3, 11, 18, 26, 19, 27,
        32, 40, 33, 34, 41, 48, 56, 49, 42, 35, 43, 50, 57, 58, 51, 59,
         4, 12,  5,  6, 13, 20, 28, 21, 14,  7, 15, 22, 29, 36, 44, 37,
        30, 23, 31, 38, 45, 52, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
    };

    logic                     CLOCK = 1'b0;
    logic                     RESET = 1'b0;
    logic                     input_valid = 1'b0;
    logic signed [DATA_W-1:0] INPUT_DATA [8][8];
    logic                     is_y = 1'b0;
    logic                     is_interlaced = 1'b0;
    logic                     in_ready;
    logic                     overflow;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic [5:0]               out_index;
    logic                     out_last;
    logic                     out_is_y;

    always #5 CLOCK = ~CLOCK;

    coef_scan_serializer #(
        .DATA_W (DATA_W)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .input_valid   (input_valid),
        .INPUT_DATA    (INPUT_DATA),
        .is_y          (is_y),
`ifdef COEF_SCAN_INTERLACED_EN
        .is_interlaced (is_interlaced),
`endif
        .in_ready      (in_ready),
        .overflow      (overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .out_is_y      (out_is_y)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name,
                               input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   data;
        int   index;
        logic last;
        logic tag;
    } beat_t;

    beat_t exp_q[$];
    int    held = 0;
    logic  exp_ov = 1'b0;
    int    model_beats = 0;
    int    accepted = 0;
    int    dut_beats = 0;
    int    valid_cycles = 0;
    bit    check_en = 1'b0;

    // Blocks held = accepted and not yet fully handshaken; a new block is
    // accepted only while fewer than two are held. Stream is valid whenever
    // any block is held.
    always @(posedge CLOCK) begin : model
        beat_t b;
        int    a;
        bit    accept;
        logic  il;
        if (!RESET) begin
            held = 0;
            exp_q.delete();
            exp_ov = 1'b0;
        end else begin
            accept = input_valid && (held < 2);
`ifdef COEF_SCAN_INTERLACED_EN
            il = is_interlaced;
`else
            il = 1'b0;
`endif
            if ((held > 0) && out_ready) begin
                b = exp_q.pop_front();
                model_beats++;
                if (b.last) held--;
            end
            if (accept) begin
                for (int k = 0; k < 64; k++) begin
                    a = il ? INTL_TBL[k] : PROG_TBL[k];
                    b.data  = INPUT_DATA[a / 8][a % 8];
                    b.index = k;
                    b.last  = (k == 63);
                    b.tag   = is_y;
                    exp_q.push_back(b);
                end
                held++;
                accepted++;
            end else if (input_valid) begin
                exp_ov = 1'b1;
            end
        end
    end

    always @(negedge CLOCK) begin : monitor
        if (check_en) begin
            if (out_valid === 1'b1) valid_cycles++;
            if (out_valid === 1'b1 && out_ready) dut_beats++;
            checkOutput("out_valid", out_valid, held > 0);
            checkOutput("in_ready", in_ready, held < 2);
            checkOutput("overflow", overflow, exp_ov);
            if (held > 0 && exp_q.size() > 0) begin
                checkOutput("out_data", out_data, exp_q[0].data);
                checkOutput("out_index", out_index, exp_q[0].index);
                checkOutput("out_last", out_last, exp_q[0].last);
                checkOutput("out_is_y", out_is_y, exp_q[0].tag);
            end else begin
                checkOutput("out_last_idle", out_last, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic fill_block(input int mode, input int value);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                case (mode)
                    0:       INPUT_DATA[r][c] = r * 8 + c;
                    1:       INPUT_DATA[r][c] = value;
                    default: INPUT_DATA[r][c] = $urandom;
                endcase
    endtask

    task automatic applyStimulus(input logic valid, input logic tag,
                                 input logic il, input logic rdy);
        input_valid   = valid;
        is_y          = tag;
        is_interlaced = il;
        out_ready     = rdy;
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        tick();
        tick();
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_index", out_index, 0);
        checkOutput("reset out_last", out_last, 1'b0);
        checkOutput("reset out_is_y", out_is_y, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset in_ready", in_ready, 1'b1);
        RESET = 1'b1;
        check_en = 1'b1;
        dut_beats = 0;
        model_beats = 0;
        valid_cycles = 0;
        accepted = 0;
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string name;
        int    num_blocks;
        int    gap;
        int    fill_mode;
        int    val0;
        int    val1;
        int    val2;
        logic  tag;
        int    ready_mode;
        int    ready_hold;
        int    run_cycles;
        int    exp_beats;
        int    exp_valid_cycles;
        logic  exp_overflow;
    } scen_t;

    scen_t scen [4];

    function automatic int pick_val(input scen_t s, input int k);
        return (k == 0) ? s.val0 : (k == 1) ? s.val1 : s.val2;
    endfunction

    function automatic logic ready_for(input scen_t s, input int c);
        case (s.ready_mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            default: return c >= s.ready_hold;
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int  k;
        bit  v;
        int  n;

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                INPUT_DATA[r][c] = 0;

        //          name           blk gap fill v0  v1  v2 tag rdy hold run beats valid ov
        scen[0] = '{"single_ramp",   1, 1,  0,  0,  0,  0, 1'b1, 0, 0,  70,  64,  64, 1'b0};
        scen[1] = '{"back_to_back",  2, 3,  1,  5, -7,  0, 1'b1, 0, 0, 140, 128, 128, 1'b0};
        scen[2] = '{"backpressure",  1, 1,  0,  0,  0,  0, 1'b0, 1, 0, 135,  64, 128, 1'b0};
        scen[3] = '{"overflow",      3, 1,  1, 11, 22, 33, 1'b1, 2, 10, 150, 128, 137, 1'b1};

        for (int s = 0; s < 4; s++) begin
            $display("[TB] scenario %s", scen[s].name);
            do_reset();
            for (int c = 0; c < scen[s].run_cycles; c++) begin
                k = c / scen[s].gap;
                v = ((c % scen[s].gap) == 0) && (k < scen[s].num_blocks);
                if (v) fill_block(scen[s].fill_mode, pick_val(scen[s], k));
                applyStimulus(v, scen[s].tag, 1'b0, ready_for(scen[s], c));
                tick();
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput({scen[s].name, " beats"}, dut_beats, scen[s].exp_beats);
            checkOutput({scen[s].name, " valid_cycles"}, valid_cycles, scen[s].exp_valid_cycles);
            checkOutput({scen[s].name, " overflow"}, overflow, scen[s].exp_overflow);
        end

        // Reset mid-drain: three blocks (third dropped), reset at beat 30.
        $display("[TB] scenario reset_mid_drain");
        do_reset();
        for (int c = 0; c < 3; c++) begin
            fill_block(0, 0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (model_beats < 30 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("reach beat 30", model_beats, 30);
        checkOutput("overflow before reset", overflow, 1'b1);
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        checkOutput("mid reset out_valid", out_valid, 1'b0);
        checkOutput("mid reset overflow", overflow, 1'b0);
        checkOutput("mid reset in_ready", in_ready, 1'b1);
        dut_beats = 0;
        fill_block(1, -3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("after reset first index", out_index, 0);
        checkOutput("after reset first data", out_data, -3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (70) tick();
        checkOutput("after reset beats", dut_beats, 64);

`ifdef COEF_SCAN_INTERLACED_EN
        $display("[TB] scenario interlaced_ramp");
        do_reset();
        fill_block(0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("interlaced beat0", out_data, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("interlaced beat1", out_data, 8);
        repeat (70) tick();
        checkOutput("interlaced beats", dut_beats, 64);
`endif

        // Randomized traffic against the model.
        $display("[TB] scenario random");
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 5) == 0);
            if (v) fill_block(2, 0);
            applyStimulus(v, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (200) tick();
        checkOutput("random beats", dut_beats, accepted * 64);
        checkOutput("random idle", out_valid, 1'b0);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
